video_pattern_source: RTL
=========================

// Module: video_pattern_source
// PURPOSE
//  Video source end of the 720p pixel interface: generates vs/hs/de timing plus RGB test patterns
//  at 74.25 MHz, driving the input side of the RGB classification pipeline for bring-up and bench runs.
//  Raster counters, run/idle FSM, frame-latched pattern select, registered outputs.
// PARAMETERS
//  H_ACTIVE 1280 active pixels/line;  H_FP 110;  H_SYNC 40;  H_BP 220  (H_TOTAL = sum = 1650)
//  V_ACTIVE 720 active lines;  V_FP 5;  V_SYNC 5;  V_BP 20  (V_TOTAL = sum = 750)
//  SYNC_POL 1   1 = hs/vs active-high, 0 = active-low
//  CHK_LOG2 5   checkerboard square = 2**CHK_LOG2 pixels
// PORTS
//  clk          in   1   pixel clock, 74.25 MHz
//  reset_n      in   1   asynchronous active-low reset
//  enable       in   1   1 = run/continue generating frames; 0 = stop at end of current frame
//  pattern_sel  in   2   0 solid, 1 colour bars, 2 gradient, 3 checkerboard
//  solid_rgb    in   24  {r,g,b} for pattern 0
//  vs_out       out  1   vertical sync
//  hs_out       out  1   horizontal sync
//  de_out       out  1   1 = valid active pixel
//  r_out        out  8   red
//  g_out        out  8   green
//  b_out        out  8   blue
//  frame_start  out  1   1-cycle pulse coincident with first active pixel (h=0,v=0) on outputs
//  running      out  1   FSM in RUN
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, h_cnt=v_cnt=0, frame_cnt=0; de_out=0, frame_start=0,
//   running=0, rgb=0, hs_out=vs_out=~SYNC_POL (inactive).
//  FSM: IDLE -> RUN when enable=1 sampled; counters start at h=v=0 next cycle. RUN -> IDLE only when
//   enable=0 sampled at h=H_TOTAL-1,v=V_TOTAL-1; never abort mid-frame. IDLE: counters held 0, outputs inactive.
//  h_cnt 0..H_TOTAL-1, wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0, frame_cnt++ (8 bit, wraps).
//  Raster (from counters): de = h<H_ACTIVE && v<V_ACTIVE;
//   hs active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC;
//   vs active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, edges at h=0).
//  Latency: all outputs registered, exactly 1 clk after counter state; vs/hs/de/rgb/frame_start mutually aligned.
//  Active pixel ordering: counter state (h,v) appears on outputs 1 clk later; first-frame
//   de_out=1 two clks after the enable=1 sample.
//  rgb forced to 0 whenever de=0.
//  pattern_sel and solid_rgb sampled only when h=0,v=0 (RUN) and held for the whole frame.
//  Patterns (x=h_cnt, y=v_cnt):
//   0 solid: {r,g,b}=solid_rgb.
//   1 bars: 8 equal bars of H_ACTIVE/8 px via bar counter (no divider), left to right:
//     white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
//   2 gradient: r=x[7:0], g=y[7:0], b=frame_cnt.
//   3 checker: FFFFFF when x[CHK_LOG2]^y[CHK_LOG2]=0, else 000000.
//  enable toggling mid-frame: no effect until frame end. Reset mid-frame: immediate return to reset state.
// TESTING
//  T1 reset: hold reset_n=0, toggle enable -> de_out=0, hs_out=vs_out=0, rgb=0, running=0 throughout.
//  T2 720p timing: enable=1 two frames -> hs period 1650 clk, hs width 40, 1280 de clk/line, 720 de lines,
//     vs width 5*1650=8250 clk, frame period 1,237,500 clk, one frame_start per frame.
//  T3 start/stop: enable=1 at cycle N -> first de_out at N+2; drop enable mid-frame -> frame completes, running=0
//     after h=1649,v=749; no de thereafter.
//  T4 bars: pattern_sel=1 -> pixels 0,159 FFFFFF; 160 FFFF00; 640 FF00FF; 1279 000000; rgb=0 outside de.
//  T5 latch/gradient/checker: sel=2 with y=3 row -> r=x[7:0], g=03, b=frame_cnt; change sel 2->3 mid-frame ->
//     switches only at next frame_start; checker px(32,0)=000000, (32,32)=FFFFFF.
//  T6 reduced params (H 16/2/2/2, V 4/1/1/1, SYNC_POL=0) + async reset mid-line -> counts scale, syncs active-low,
//     outputs return to reset values immediately on reset_n=0.

Source files
------------

// File: rtl/video_pattern_source.sv
`default_nettype none
// ============================================================================
// Module : video_pattern_source
// Raster timing generator (vs/hs/de) with frame-latched RGB test patterns.
// Rev    : 1.0
// ============================================================================
module video_pattern_source #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1,
  parameter int CHK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [23:0]   solid_q, solid_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic          vs_q, vs_d, hs_q, hs_d, de_q, de_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          w_run;
  logic          w_first;
  logic [1:0]    w_sel;
  logic [23:0]   w_solid;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_pix;

  // Counters, FSM and the per-frame pattern latch.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    sel_d       = sel_q;
    solid_d     = solid_q;
    bar_px_d    = bar_px_q;
    bar_idx_d   = bar_idx_q;
    case (state_q)
      S_IDLE: begin
        h_d       = '0;
        v_d       = '0;
        bar_px_d  = '0;
        bar_idx_d = '0;
        if (enable) state_d = S_RUN;
      end
      default: begin
        if (w_first) begin
          sel_d   = pattern_sel;
          solid_d = solid_rgb;
        end
        if (h_q == H_LAST) begin
          h_d       = '0;
          bar_px_d  = '0;
          bar_idx_d = '0;
          if (v_q == V_LAST) begin
            v_d         = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!enable) state_d = S_IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
          // Bar index tracks h without a divide: step every BAR_W pixels.
          if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_px_d = bar_px_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    case (bar_idx_q)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  // Output stage inputs; the first pixel uses the freshly sampled selection.
  always_comb begin
    w_run    = (state_q == S_RUN);
    w_first  = w_run && (h_q == '0) && (v_q == '0);
    w_sel    = w_first ? pattern_sel : sel_q;
    w_solid  = w_first ? solid_rgb : solid_q;
    w_hs_act = w_run && (h_q >= HS_BEG) && (h_q < HS_END);
    w_vs_act = w_run && (v_q >= VS_BEG) && (v_q < VS_END);
    de_d     = w_run && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d     = w_hs_act ? SYNC_ON : ~SYNC_ON;
    vs_d     = w_vs_act ? SYNC_ON : ~SYNC_ON;
    fs_d     = w_first;
    case (w_sel)
      2'd0:    w_pix = w_solid;
      2'd1:    w_pix = w_bar_rgb;
      2'd2:    w_pix = {8'(h_q), 8'(v_q), frame_cnt_q};
      default: w_pix = (h_q[CHK_LOG2] ^ v_q[CHK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
    endcase
    rgb_d = de_d ? w_pix : 24'h000000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      sel_q       <= '0;
      solid_q     <= '0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      vs_q        <= ~SYNC_ON;
      hs_q        <= ~SYNC_ON;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      sel_q       <= sel_d;
      solid_q     <= solid_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      rgb_q       <= rgb_d;
    end
  end

  assign vs_out      = vs_q;
  assign hs_out      = hs_q;
  assign de_out      = de_q;
  assign frame_start = fs_q;
  assign r_out       = rgb_q[23:16];
  assign g_out       = rgb_q[15:8];
  assign b_out       = rgb_q[7:0];
  assign running     = (state_q == S_RUN);

endmodule
`default_nettype wire
